// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS fetch-stage PC register with IDLE/RUN/WAIT/HALT run control.
// Optional macro PC_ALIGN_CHECK_EN: a misaligned branch/jump target sets sticky misaligned and halts.
module pc_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                step_mode,
    input  logic                step,
    input  logic                clear,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                halt_detect,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                fetch_valid,
    output logic                halted,
    output logic [1:0]          state,
    output logic                misaligned
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2, S_HALT = 2'd3} state_t;
    state_t cur, nxt;
    logic [PC_WIDTH-1:0] pc_nxt, tgt;
    logic fv_nxt, adv, redirect, bad;
    assign pc_plus4 = pc + PC_WIDTH'(4);
    assign state    = cur;
    assign halted   = (cur == S_HALT);
    assign adv      = (cur == S_RUN) || (cur == S_WAIT && step);
    assign redirect = branch_taken || jump;
    assign tgt      = branch_taken ? branch_target : jump_target;
`ifdef PC_ALIGN_CHECK_EN
    logic mis_q;
    assign bad        = redirect && (tgt[1:0] != 2'b00);
    assign misaligned = mis_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= !clear && (mis_q || (adv && bad));
`else
    assign bad        = 1'b0;
    assign misaligned = 1'b0;
`endif
    // A HALT on the flushed path behind a taken branch must not stop the machine.
    always_comb begin
        nxt    = cur;
        pc_nxt = pc;
        fv_nxt = 1'b0;
        if (clear) begin
            nxt    = S_IDLE;
            pc_nxt = RESET_PC;
        end else begin
            if (cur == S_IDLE && start) nxt = step_mode ? S_WAIT : S_RUN;
            if (cur == S_WAIT && start && !step_mode) nxt = S_RUN;
            if (adv) begin
                if ((halt_detect && !branch_taken) || bad) nxt = S_HALT;
                else if (redirect) begin
                    pc_nxt = tgt;
                    fv_nxt = 1'b1;
                end else if (!stall) begin
                    pc_nxt = pc_plus4;
                    fv_nxt = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur         <= S_IDLE;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
        end else begin
            cur         <= nxt;
            pc          <= pc_nxt;
            fetch_valid <= fv_nxt;
        end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a rule-level reference model.
module tb_pc_sequencer;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic start, step_mode, step, clear, stall, branch_taken, jump, halt_detect;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, pc_plus4;
    logic fetch_valid, halted, misaligned;
    logic [1:0] state;
    int checks = 0, errors = 0;
    int ms;
    logic [31:0] mpc;
    logic mfv, mmis;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .clear(clear), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt_detect(halt_detect), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .halted(halted), .state(state),
        .misaligned(misaligned)
    );

    task automatic zero_inputs();
        start = 0; step_mode = 0; step = 0; clear = 0; stall = 0;
        branch_taken = 0; jump = 0; halt_detect = 0;
        branch_target = 0; jump_target = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({pc, pc_plus4, fetch_valid, halted, state, misaligned} !== {32'h0, 32'h4, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: pc=%h pc4=%h fv=%b halted=%b state=%0d mis=%b", pc, pc_plus4, fetch_valid, halted, state, misaligned);
        end
    endtask

    task automatic test_run();
        start = 1; tick(); start = 0;
        checks++;
        if ({pc, fetch_valid, state} !== {32'h0, 1'b0, 2'd1}) begin
            errors++; $display("FAIL run_enter: pc=%h fv=%b state=%0d want pc=0 fv=0 state=1", pc, fetch_valid, state);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({pc, fetch_valid, state} !== {32'(4 * i), 1'b1, 2'd1}) begin
                errors++; $display("FAIL run_seq%0d: pc=%h fv=%b state=%0d want pc=%h fv=1 state=1", i, pc, fetch_valid, state, 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        jump = 1; jump_target = 32'hFFFF_FFF8; tick(); jump = 0;
        checks++;
        if ({pc, fetch_valid} !== {32'hFFFF_FFF8, 1'b1}) begin
            errors++; $display("FAIL wrap_jump: pc=%h fv=%b want FFFFFFF8 1", pc, fetch_valid);
        end
        tick();
        checks++;
        if ({pc, pc_plus4} !== {32'hFFFF_FFFC, 32'h0}) begin
            errors++; $display("FAIL wrap_pc4: pc=%h pc4=%h want FFFFFFFC 00000000", pc, pc_plus4);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL wrap_zero: pc=%h want 00000000", pc);
        end
    endtask

    task automatic test_priority();
        jump = 1; jump_target = 32'h20; tick(); jump = 0;
        checks++;
        if (pc !== 32'h20) begin
            errors++; $display("FAIL prio_setup: pc=%h want 20", pc);
        end
        stall = 1; jump = 1; jump_target = 32'h100; branch_taken = 1; branch_target = 32'h40;
        tick(); zero_inputs();
        checks++;
        if ({pc, fetch_valid} !== {32'h40, 1'b1}) begin
            errors++; $display("FAIL prio_branch: pc=%h fv=%b want 40 1", pc, fetch_valid);
        end
        stall = 1; tick(); tick(); stall = 0;
        checks++;
        if ({pc, fetch_valid} !== {32'h40, 1'b0}) begin
            errors++; $display("FAIL prio_stall: pc=%h fv=%b want 40 0", pc, fetch_valid);
        end
        halt_detect = 1; branch_taken = 1; branch_target = 32'h80; tick(); zero_inputs();
        checks++;
        if ({pc, state} !== {32'h80, 2'd1}) begin
            errors++; $display("FAIL prio_halt_flush: pc=%h state=%0d want 80 1", pc, state);
        end
    endtask

    task automatic test_step();
        clear = 1; start = 1; tick(); zero_inputs();
        checks++;
        if ({pc, state} !== {32'h0, 2'd0}) begin
            errors++; $display("FAIL step_clear_wins: pc=%h state=%0d want 0 0", pc, state);
        end
        start = 1; step_mode = 1; tick(); zero_inputs();
        checks++;
        if ({pc, state} !== {32'h0, 2'd2}) begin
            errors++; $display("FAIL step_enter: pc=%h state=%0d want 0 2", pc, state);
        end
        for (int i = 1; i <= 3; i++) begin
            step = 1; tick(); step = 0;
            checks++;
            if ({pc, fetch_valid, state} !== {32'(4 * i), 1'b1, 2'd2}) begin
                errors++; $display("FAIL step_pulse%0d: pc=%h fv=%b state=%0d want %h 1 2", i, pc, fetch_valid, state, 32'(4 * i));
            end
            tick();
            checks++;
            if ({pc, fetch_valid} !== {32'(4 * i), 1'b0}) begin
                errors++; $display("FAIL step_gap%0d: pc=%h fv=%b want %h 0", i, pc, fetch_valid, 32'(4 * i));
            end
        end
        step = 1; repeat (3) tick(); step = 0;
        checks++;
        if (pc !== 32'd24) begin
            errors++; $display("FAIL step_held: pc=%h want 18", pc);
        end
        start = 1; tick(); start = 0;
        checks++;
        if ({pc, state} !== {32'd24, 2'd1}) begin
            errors++; $display("FAIL step_to_run: pc=%h state=%0d want 18 1", pc, state);
        end
    endtask

    task automatic test_halt();
        clear = 1; tick(); clear = 0;
        start = 1; tick(); start = 0;
        jump = 1; jump_target = 32'h10; tick(); jump = 0;
        halt_detect = 1; tick(); halt_detect = 0;
        checks++;
        if ({pc, state, halted, fetch_valid} !== {32'h10, 2'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL halt_enter: pc=%h state=%0d halted=%b fv=%b want 10 3 1 0", pc, state, halted, fetch_valid);
        end
        start = 1; step = 1; repeat (2) tick(); zero_inputs();
        checks++;
        if ({pc, state} !== {32'h10, 2'd3}) begin
            errors++; $display("FAIL halt_frozen: pc=%h state=%0d want 10 3", pc, state);
        end
        clear = 1; tick(); clear = 0;
        checks++;
        if ({pc, state, halted} !== {32'h0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL halt_clear: pc=%h state=%0d halted=%b want 0 0 0", pc, state, halted);
        end
    endtask

    task automatic test_misaligned();
        start = 1; tick(); start = 0;
        jump = 1; jump_target = 32'h102; tick(); jump = 0;
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if ({pc, state, misaligned} !== {32'h0, 2'd3, 1'b1}) begin
            errors++; $display("FAIL mis_flag: pc=%h state=%0d mis=%b want 0 3 1", pc, state, misaligned);
        end
        tick();
        checks++;
        if ({pc, misaligned} !== {32'h0, 1'b1}) begin
            errors++; $display("FAIL mis_sticky: pc=%h mis=%b want 0 1", pc, misaligned);
        end
        clear = 1; tick(); clear = 0;
        checks++;
        if ({state, misaligned} !== {2'd0, 1'b0}) begin
            errors++; $display("FAIL mis_clear: state=%0d mis=%b want 0 0", state, misaligned);
        end
`else
        checks++;
        if ({pc, state, misaligned} !== {32'h102, 2'd1, 1'b0}) begin
            errors++; $display("FAIL mis_off: pc=%h state=%0d mis=%b want 102 1 0", pc, state, misaligned);
        end
        clear = 1; tick(); clear = 0;
`endif
    endtask

    task automatic test_async_reset();
        start = 1; tick(); start = 0;
        repeat (3) tick();
        #3 rst_n = 0;
        #1;
        checks++;
        if ({pc, pc_plus4, fetch_valid, state, halted, misaligned} !== {32'h0, 32'h4, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset: pc=%h pc4=%h fv=%b state=%0d want 0 4 0 0", pc, pc_plus4, fetch_valid, state);
        end
        @(posedge clk); #1 rst_n = 1;
    endtask

    // Reference: what the sequencer should do this cycle, from the run-control rules.
    task automatic model_step();
        logic [31:0] t;
        bit adv, bad;
        if (clear) begin
            ms = 0; mpc = 32'h0; mfv = 0; mmis = 0;
            return;
        end
        mfv = 0;
        adv = (ms == 1) || (ms == 2 && step);
        if (ms == 0 && start) ms = step_mode ? 2 : 1;
        else if (ms == 2 && start && !step_mode) ms = 1;
        if (!adv) return;
        t = branch_taken ? branch_target : jump_target;
        bad = ALIGN && (branch_taken || jump) && (t % 4 != 0);
        if ((halt_detect && !branch_taken) || bad) begin
            ms = 3;
            if (bad) mmis = 1;
        end else if (branch_taken || jump) begin
            mpc = t; mfv = 1;
        end else if (!stall) begin
            mpc = mpc + 32'd4; mfv = 1;
        end
    endtask

    task automatic test_random();
        zero_inputs(); clear = 1; tick();
        ms = 0; mpc = 32'h0; mfv = 0; mmis = 0;
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(39) == 0);
            start = ($urandom_range(7) == 0);
            step_mode = $urandom_range(1);
            step = ($urandom_range(2) == 0);
            stall = ($urandom_range(3) == 0);
            branch_taken = ($urandom_range(5) == 0);
            jump = ($urandom_range(5) == 0);
            halt_detect = ($urandom_range(19) == 0);
            branch_target = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(9) == 0) ? 32'd2 : 32'd0);
            jump_target = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(9) == 0) ? 32'd1 : 32'd0);
            model_step();
            tick();
            checks++;
            if ({pc, pc_plus4, fetch_valid, state, halted, misaligned} !== {mpc, 32'(mpc + 32'd4), mfv, 2'(ms), ms == 3, mmis}) begin
                errors++;
                $display("FAIL random%0d: pc=%h pc4=%h fv=%b st=%0d h=%b mis=%b want pc=%h fv=%b st=%0d mis=%b",
                         i, pc, pc_plus4, fetch_valid, state, halted, misaligned, mpc, mfv, ms, mmis);
            end
        end
        zero_inputs();
    endtask

    initial begin
        zero_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_run();
        test_wrap();
        test_priority();
        test_step();
        test_halt();
        test_misaligned();
        test_async_reset();
        test_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
